// File: rtl/dump_pkg.sv
// Shared definitions for the architectural state dump streamer (FSM states, sizes, index width).
// Latency: n/a, definitions only.
// Backpressure: n/a. The ST_CSUM state exists only when DUMP_CHECKSUM_EN is defined.
package dump_pkg;

    // Default dump sizes: full integer register file plus a small data-memory window.
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_DMEM = 16;

    // Stream index width; must hold NUM_REGS + NUM_DMEM (+1 for the checksum word).
    localparam int IDX_W = 6;

    // Read address widths of the register file and the data-memory window.
    localparam int RF_AW = 5;
    localparam int DM_AW = 4;

    // The state names the section of the word currently held in the output register.
`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REG  = 2'd1,
        ST_MEM  = 2'd2,
        ST_CSUM = 2'd3
    } dump_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REG  = 2'd1,
        ST_MEM  = 2'd2
    } dump_state_e;
`endif

endpackage

// File: rtl/arch_state_dump.sv
// Streams register file then data memory (optionally an XOR checksum word, DUMP_CHECKSUM_EN) as indexed words.
// Latency: first word valid 1 cycle after dump_req is sampled in idle; one word per cycle while out_ready is high.
// Backpressure: valid/ready; the output register holds data/idx/last while out_valid && !out_ready.
module arch_state_dump
    import dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_DMEM = DEF_NUM_DMEM,
    parameter int DWIDTH   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_req,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DWIDTH-1:0] rf_rdata,
    output logic [DM_AW-1:0]  dm_raddr,
    input  logic [DWIDTH-1:0] dm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    // Stream index landmarks.
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_BASE = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_REGS + NUM_DMEM - 1);
`ifdef DUMP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_REGS + NUM_DMEM);
    localparam logic [IDX_W-1:0] LAST_IDX = CSUM_IDX;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = LAST_MEM;
`endif

    dump_state_e       state_q;
    dump_state_e       state_d;
    logic              hs;
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  mem_off;
    logic [DWIDTH-1:0] load_word;
    logic [DWIDTH-1:0] out_data_d;
    logic [IDX_W-1:0]  out_idx_d;
    logic              out_last_d;
`ifdef DUMP_CHECKSUM_EN
    logic [DWIDTH-1:0] csum_q;
    logic [DWIDTH-1:0] csum_d;
`endif

    // Index of the word that will be loaded next, and the read addresses that fetch it.
    // The memories are read combinationally so a load can happen in the same cycle as a handshake.
    always_comb begin
        load_idx = (state_q == ST_IDLE) ? '0 : out_idx + IDX_W'(1);
        mem_off  = load_idx - MEM_BASE;
        rf_raddr = '0;
        dm_raddr = '0;
        if (state_q != ST_IDLE) begin
            if (load_idx < MEM_BASE) begin
                rf_raddr = RF_AW'(load_idx);
            end else if (load_idx <= LAST_MEM) begin
                dm_raddr = DM_AW'(mem_off);
            end
        end
    end

    // Select the word to load: r0 is architecturally zero, then regs, then dmem (then checksum).
    always_comb begin
        load_word = dm_rdata;
        if (load_idx == '0) begin
            load_word = '0;
        end else if (load_idx < MEM_BASE) begin
            load_word = rf_rdata;
        end
`ifdef DUMP_CHECKSUM_EN
        else if (load_idx == CSUM_IDX) begin
            load_word = csum_q;
        end
`endif
    end

    // Next-state and output-register update; a handshake reloads the output register in the same cycle.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data;
        out_idx_d  = out_idx;
        out_last_d = out_last;
        load       = 1'b0;
        out_valid  = (state_q != ST_IDLE);
        busy       = (state_q != ST_IDLE);
        hs         = out_valid && out_ready;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    state_d = ST_REG;
                    load    = 1'b1;
                end
            end
            ST_REG: begin
                if (hs) begin
                    load = 1'b1;
                    if (out_idx == LAST_REG) begin
                        state_d = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (hs) begin
                    if (out_idx == LAST_MEM) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
                        load    = 1'b1;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        load = 1'b1;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (hs) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            out_data_d = load_word;
            out_idx_d  = load_idx;
            out_last_d = (load_idx == LAST_IDX);
`ifdef DUMP_CHECKSUM_EN
            // Checksum restarts with word 0 of each dump and folds in every loaded word.
            csum_d     = (state_q == ST_IDLE) ? load_word : (csum_q ^ load_word);
`endif
        end else if (state_d == ST_IDLE) begin
            out_last_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            out_data <= out_data_d;
            out_idx  <= out_idx_d;
            out_last <= out_last_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: doc/arch_state_dump.md
ARCH_STATE_DUMP -- requirements
Module: arch_state_dump

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of register-file words to dump.
REQ-002 SHALL have parameter NUM_DMEM, default 16: number of data-memory words to dump.
REQ-003 SHALL have parameter DWIDTH, default 32: data word width.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port dump_req, input, 1: start a dump; sampled only in IDLE.
REQ-007 SHALL have port rf_raddr, output, 5: register-file read address.
REQ-008 SHALL have port rf_rdata, input, DWIDTH: combinational read data for rf_raddr.
REQ-009 SHALL have port dm_raddr, output, 4: dmem word read address.
REQ-010 SHALL have port dm_rdata, input, DWIDTH: combinational read data for dm_raddr.
REQ-011 SHALL have port out_valid, output, 1: out_data/out_idx/out_last valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the word when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, DWIDTH: dumped word.
REQ-014 SHALL have port out_idx, output, 6: stream index; 0..NUM_REGS-1 are regs, then dmem words.
REQ-015 SHALL have port out_last, output, 1: marks the final word of the dump.
REQ-016 SHALL have port busy, output, 1: high from dump acceptance until the last word is accepted.

Function
REQ-017 SHALL implement FSM IDLE -> REG -> MEM -> (CSUM) -> IDLE.
REQ-018 SHALL, in IDLE with dump_req=1, load index 0 into the output register and assert out_valid and busy on the next cycle (1-cycle latency).
REQ-019 SHALL hold out_data, out_idx and out_last stable while out_valid && !out_ready.
REQ-020 SHALL, on each handshake, load the next word in the same cycle so that a continuously high out_ready yields one word per cycle.
REQ-021 SHALL emit reg index k from rf_rdata at rf_raddr=k, and dmem word j at out_idx NUM_REGS+j from dm_rdata at dm_raddr=j.
REQ-022 SHALL emit register 0 as 0 regardless of rf_rdata.
REQ-023 SHALL move REG -> MEM on the handshake of out_idx NUM_REGS-1, and MEM -> IDLE (or CSUM) on the handshake of out_idx NUM_REGS+NUM_DMEM-1.
REQ-024 SHALL return to IDLE with out_valid=0 and busy=0 in the cycle after the last-word handshake; a dump_req in that same cycle is accepted.
REQ-025 SHALL ignore dump_req while busy=1.
REQ-026 SHALL drive rf_raddr/dm_raddr to 0 in IDLE.

Reset
REQ-027 SHALL, on rst=1 at posedge clk, set state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0 and busy=0, aborting any dump in progress without completing it.

Configuration
REQ-028 SHALL, with DUMP_CHECKSUM_EN defined, append one word at out_idx NUM_REGS+NUM_DMEM equal to the XOR of all preceding emitted words, with out_last on that word only.
REQ-029 SHALL, without DUMP_CHECKSUM_EN, have no CSUM state and assert out_last on out_idx NUM_REGS+NUM_DMEM-1.

Structure
REQ-030 SHALL place the FSM state enum, NUM_REGS/NUM_DMEM defaults and the index width in shared package dump_pkg.
REQ-031 SHALL be a single module; no sub-module is needed.

Verification
REQ-032 SHALL test: regs r8=23, r9=68, r10=68, r11=23, dmem[2]=68 with all others 0, dump_req pulse and out_ready=1 -> 48 words on consecutive cycles, idx8=23, idx9=68, idx10=68, idx11=23, idx34=68, out_last at idx47.
REQ-033 SHALL test: same contents with DUMP_CHECKSUM_EN -> word idx48=68, out_last only at idx48.
REQ-034 SHALL test: out_ready low for 3 cycles at idx5 -> out_data/out_idx held at idx5, no word skipped or duplicated.
REQ-035 SHALL test: rf_rdata forced to 0xFFFFFFFF at address 0 -> idx0 emits 0.
REQ-036 SHALL test: rst asserted at idx20 -> next cycle out_valid=0 and busy=0; a new dump_req restarts at idx0.
REQ-037 SHALL test: dump_req held high throughout -> first dump completes intact, and a second dump starts on the cycle after the last-word handshake.
